// File: rtl/cache_fill_ctrl_pkg.sv
// cache_fill_ctrl_pkg
//   Shared definitions for the cache miss handler.
//   - fill_state_e      : controller states (IDLE waits for a miss, FILL streams a block in)
//   - BLOCK_OFFSET_BITS : byte-offset bits inside one cache block (16-byte blocks)
//   - WORD_IDX_BITS     : word-index bits inside one cache block (8 words)
package cache_fill_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;

endpackage

// File: rtl/cache_fill_ctrl_cnt_3bit.sv
// cnt_3bit
//   Word counter used by the fill controller, one instance each for the
//   request side and the return side of a block fill.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-high reset, clears the count
//     clr  : synchronous clear (wins over inc)
//     inc  : increment by one, wrapping from 7 to 0
//     cnt  : current count
//     term : count is at its terminal value (7)
module cnt_3bit
    import cache_fill_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [WORD_IDX_BITS-1:0] cnt,
    output logic                     term
);

    localparam logic [WORD_IDX_BITS-1:0] CNT_ONE = 1;

    logic [WORD_IDX_BITS-1:0] cnt_d;
    logic [WORD_IDX_BITS-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == '1);

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
//   Miss handler between a cache (instruction or data) and multi-cycle main
//   memory. On a miss it requests all 8 words of the 16-byte block on
//   consecutive cycles, writes each returned word into the cache data array
//   as it arrives, and writes the tag array together with the last word.
//   fsm_busy stalls the pipeline from the miss cycle until the fill is done.
//   Ports:
//     clk, rst           : clock, asynchronous active-high reset
//     miss_detected      : cache lookup missed (only looked at while idle)
//     miss_address       : byte address of the missing access
//     memory_data_valid  : memory returns one word this cycle (in request order)
//     memory_data        : returned word
//     fsm_busy           : fill in progress, pipeline must stall
//     mem_en             : read request to memory this cycle
//     memory_address     : address of that request
//     write_data_array   : write fill_data into word fill_word_idx of the block
//     fill_word_idx      : word index being written
//     fill_data          : word being written
//     write_tag_array    : write tag/valid for the block at fill_base
//     fill_base          : base address of the block being filled
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        fill_word_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_base
);

    // A return in the same cycle as the first request would be missed while
    // still idle, so the memory must take at least one cycle.
    if (WORDS_PER_BLOCK != (1 << WORD_IDX_BITS) || MEM_LATENCY < 1 ||
        ADDR_W <= BLOCK_OFFSET_BITS) begin : g_param_check
        $error("cache_fill_ctrl: unsupported parameter combination");
    end

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);

    fill_state_e       state_d, state_q;
    logic [ADDR_W-1:0] fill_base_d, fill_base_q;

    logic [WORD_IDX_BITS-1:0] req_cnt, rcv_cnt;
    logic                     req_term, rcv_term;
    logic                     req_clr, req_inc, rcv_clr, rcv_inc;

    logic [ADDR_W-1:0] miss_base;

    assign miss_base = miss_address & ~OFFSET_MASK;

    cnt_3bit u_req_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (req_clr),
        .inc  (req_inc),
        .cnt  (req_cnt),
        .term (req_term)
    );

    cnt_3bit u_rcv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (rcv_clr),
        .inc  (rcv_inc),
        .cnt  (rcv_cnt),
        .term (rcv_term)
    );

    always_comb begin
        state_d          = state_q;
        fill_base_d      = fill_base_q;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_idx    = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;
        req_clr          = 1'b0;
        req_inc          = 1'b0;
        rcv_clr          = 1'b0;
        rcv_inc          = 1'b0;

        unique case (state_q)
            IDLE: begin
                rcv_clr = 1'b1;
                // rst is checked here so that every output reads 0 while reset
                // is held, even if the pipeline keeps miss_detected high.
                if (miss_detected && !rst) begin
                    fsm_busy       = 1'b1;
                    fill_base_d    = miss_base;
                    mem_en         = 1'b1;
                    memory_address = miss_base;
                    req_inc        = 1'b1;
                    state_d        = FILL;
                end else begin
                    req_clr = 1'b1;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                // Word 0 went out in the miss cycle, so FILL starts at count 1.
                // After word 7 is requested the counter returns to 0, which
                // marks the request side as finished for the rest of the fill.
                if (req_cnt != '0) begin
                    mem_en         = 1'b1;
                    memory_address = fill_base_q + ADDR_W'({req_cnt, 1'b0});
                    req_inc        = 1'b1;
                    req_clr        = req_term;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_word_idx    = rcv_cnt;
                    fill_data        = memory_data;
                    rcv_inc          = 1'b1;
                    if (rcv_term) begin
                        write_tag_array = 1'b1;
                        rcv_clr         = 1'b1;
                        req_clr         = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_base_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_base_q <= fill_base_d;
        end
    end

    assign fill_base = fill_base_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl
//   Bench for cache_fill_ctrl. The bench plays main memory with a fixed
//   latency and predicts every output from the fill timeline: a miss taken in
//   cycle 0 requests word k in cycle k, sees word k return in cycle L+k, and
//   writes the tag in cycle L+7.
module tb_cache_fill_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int L      = 4;

    logic              clk;
    logic              rst;
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [DATA_W-1:0] memory_data;
    logic              fsm_busy;
    logic              mem_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [2:0]        fill_word_idx;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;
    logic [ADDR_W-1:0] fill_base;

    cache_fill_ctrl #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .WORDS_PER_BLOCK (8),
        .MEM_LATENCY     (L)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_idx     (fill_word_idx),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_base         (fill_base)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position in the fill timeline (-1 = no fill) and the
    // block base of the current/last fill.
    int              fill_pos;
    logic [15:0]     base_m;

    int n_checks;
    int n_fail;

    // Observations gathered during one fill for the directed summaries.
    int          n_req_seen;
    int          n_tag_seen;
    int          tag_pos_seen;
    logic [15:0] tag_base_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then
    // advance the model at the rising edge.
    task automatic cycle(input logic miss_v, input logic [15:0] addr_v,
                         input logic spur_v, input logic rst_v);
        logic        e_busy, e_men, e_wda, e_wta;
        logic [15:0] e_addr, e_base;
        int          e_idx;

        rst           = rst_v;
        miss_detected = miss_v;
        miss_address  = addr_v;
        memory_data   = 16'($urandom);
        if (fill_pos >= L)
            memory_data_valid = 1'b1;
        else if (fill_pos < 0)
            memory_data_valid = spur_v;
        else
            memory_data_valid = 1'b0;

        e_busy = 1'b0; e_men = 1'b0; e_wda = 1'b0; e_wta = 1'b0;
        e_addr = 16'h0; e_idx = 0;
        e_base = rst_v ? 16'h0 : base_m;
        if (!rst_v) begin
            if (fill_pos < 0) begin
                if (miss_v) begin
                    e_busy = 1'b1;
                    e_men  = 1'b1;
                    e_addr = addr_v & 16'hFFF0;
                end
            end else begin
                e_busy = 1'b1;
                e_men  = (fill_pos < 8);
                e_addr = base_m + 16'(2 * fill_pos);
                e_wda  = (fill_pos >= L);
                e_idx  = fill_pos - L;
                e_wta  = (fill_pos == L + 7);
            end
        end

        @(negedge clk);
        chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
        chk("mem_en", 32'(mem_en), 32'(e_men));
        chk("write_data_array", 32'(write_data_array), 32'(e_wda));
        chk("write_tag_array", 32'(write_tag_array), 32'(e_wta));
        chk("fill_base", 32'(fill_base), 32'(e_base));
        if (e_men)
            chk("memory_address", 32'(memory_address), 32'(e_addr));
        if (e_wda) begin
            chk("fill_word_idx", 32'(fill_word_idx), 32'(e_idx));
            chk("fill_data", 32'(fill_data), 32'(memory_data));
        end
        if (mem_en) n_req_seen++;
        if (write_tag_array) begin
            n_tag_seen++;
            tag_pos_seen  = fill_pos;
            tag_base_seen = fill_base;
        end

        @(posedge clk);
        if (rst_v) begin
            fill_pos = -1;
            base_m   = 16'h0;
        end else if (fill_pos < 0) begin
            if (miss_v) begin
                fill_pos = 1;
                base_m   = addr_v & 16'hFFF0;
            end
        end else if (fill_pos == L + 7) begin
            fill_pos = -1;
        end else begin
            fill_pos++;
        end
        #1;
    endtask

    task automatic run_idle(input int n, input logic spur_rand);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 16'($urandom), spur_rand ? 1'($urandom) : 1'b0, 1'b0);
    endtask

    // Starts a fill at addr_v and runs it to the end. A second miss
    // (intr_addr) is pulsed at fill cycle intr_at, reset at fill cycle rst_at
    // (-1 disables either).
    task automatic run_fill(input logic [15:0] addr_v, input int intr_at,
                            input logic [15:0] intr_addr, input int rst_at);
        int pos;
        n_req_seen   = 0;
        n_tag_seen   = 0;
        tag_pos_seen = -1;
        tag_base_seen = 16'h0;
        pos = 0;
        cycle(1'b1, addr_v, 1'b0, 1'b0);
        while (fill_pos >= 0 && pos < 30) begin
            pos++;
            cycle(pos == intr_at, (pos == intr_at) ? intr_addr : 16'($urandom),
                  1'b0, pos == rst_at);
        end
        chk("fill_bounded", 32'(pos < 30), 32'd1);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        fill_pos          = -1;
        base_m            = 16'h0;
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        @(posedge clk);
        #1;

        // Reset held, then released with no miss: everything stays 0.
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
        run_idle(20, 1'b0);

        // Plain fill of 0x1234.
        run_fill(16'h1234, -1, 16'h0, -1);
        chk("t2_requests", 32'(n_req_seen), 32'd8);
        chk("t2_tag_cycle", 32'(tag_pos_seen), 32'(L + 7));
        chk("t2_tag_base", 32'(tag_base_seen), 32'h1230);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);

        // Top of the address space: no carry past 0xFFFE.
        run_fill(16'hFFFB, -1, 16'h0, -1);
        chk("t3_tag_base", 32'(tag_base_seen), 32'hFFF0);
        run_idle(2, 1'b0);

        // Miss pulsed during a fill is ignored.
        run_fill(16'h1230, 3, 16'h4000, -1);
        chk("t4_requests", 32'(n_req_seen), 32'd8);
        chk("t4_tag_base", 32'(tag_base_seen), 32'h1230);
        chk("t4_fill_base", 32'(fill_base), 32'h1230);
        run_idle(2, 1'b0);

        // Reset in the middle of a fill: no tag write, then a clean fill.
        run_fill(16'h5678, -1, 16'h0, 6);
        chk("t5_no_tag", 32'(n_tag_seen), 32'd0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        run_fill(16'h0020, -1, 16'h0, -1);
        chk("t5_refill_tag", 32'(tag_base_seen), 32'h0020);

        // Spurious valids while idle, then back-to-back misses.
        run_idle(6, 1'b1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        run_fill(16'h2468, -1, 16'h0, -1);
        run_fill(16'h9ABC, -1, 16'h0, -1);
        chk("t6_second_tag", 32'(tag_base_seen), 32'h9AB0);
        run_idle(1, 1'b1);

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            int ia;
            int ra;
            run_idle($urandom_range(0, 3), 1'b1);
            ia = ($urandom_range(0, 1) == 1) ? $urandom_range(1, L + 7) : -1;
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(1, L + 7) : -1;
            run_fill(16'($urandom), ia, 16'($urandom), ra);
            if (ra < 0) chk("rnd_one_tag", 32'(n_tag_seen), 32'd1);
        end
        run_idle(3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
